vga_fb_arbiter: RTL and testbench

Arbiter and sequencer for the single-port 8-bit VGA frame buffer (225×225, 50625 entries). It shares the memory port between the display pixel fetcher, which has absolute priority inside the active image window, and a CPU write port, which is granted only on cycles with no display read. It generates the raster read address, returns the pixel stream aligned to a fixed latency, and drives black outside the window. It sits between the VGA sync generator (hcount/vcount) and the frame-buffer RAM, with the CPU bus bridge on its write side.

---
 rtl/vga_fb_pkg.sv | 11 +
 rtl/fb_window_decode.sv | 19 +
 rtl/vga_fb_arbiter.sv | 100 ++++++++++
 tb/tb_vga_fb_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - window geometry, frame-buffer depth and arbiter state type
package vga_fb_pkg;
  localparam int X0       = 200;
  localparam int Y0       = 150;
  localparam int IMG_W    = 225;
  localparam int IMG_H    = 225;
  localparam int FB_DEPTH = IMG_W * IMG_H;
  localparam int ADDR_W   = 16;

  typedef enum logic [1:0] {IDLE, WRITE, ERR} fb_state_t;
endpackage

// File: rtl/fb_window_decode.sv
// rtl/fb_window_decode.sv - inclusive image-window test on the raw raster counters
module fb_window_decode
  import vga_fb_pkg::*;
#(
  parameter int WX0 = X0,
  parameter int WY0 = Y0,
  parameter int W   = IMG_W,
  parameter int H   = IMG_H
) (
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        in_win,
  output logic        in_vwin
);
  always_comb begin
    in_vwin = (vcount >= 10'(WY0)) && (vcount <= 10'(WY0 + H - 1));
    in_win  = in_vwin && (hcount >= 11'(WX0)) && (hcount <= 11'(WX0 + W - 1));
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer port arbiter: display reads first, CPU writes in gaps
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        out_pixels,
  output logic              out_valid
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(FB_DEPTH);

  logic              in_win, in_vwin;
  logic [ADDR_W-1:0] rd_ptr;
  fb_state_t         state, state_n;
  logic              grant_wr, grant_err;
  logic              rd_v1, rd_v2;

  fb_window_decode u_win (
    .hcount  (hcount),
    .vcount  (vcount),
    .in_win  (in_win),
    .in_vwin (in_vwin)
  );

  // Raster address counts pixels, so no x*IMG_W product is needed.
  always_ff @(posedge clk) begin
    if (rst || !in_vwin)
      rd_ptr <= '0;
    else if (in_win)
      rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // WRITE/ERR last one cycle, which caps CPU throughput at one request per two clocks.
  always_comb begin
    state_n   = state;
    grant_wr  = 1'b0;
    grant_err = 1'b0;
    case (state)
      IDLE: begin
        if (!in_win && wr_valid) begin
          if (wr_addr < DEPTH_A) begin
            state_n  = WRITE;
            grant_wr = 1'b1;
          end else begin
            state_n   = ERR;
            grant_err = 1'b1;
          end
        end
      end
      WRITE, ERR: state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ready   <= 1'b0;
      wr_err     <= 1'b0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      out_pixels <= '0;
      out_valid  <= 1'b0;
    end else begin
      mem_we   <= grant_wr;
      wr_ready <= grant_wr || grant_err;
      wr_err   <= grant_err;
      if (in_win) begin
        mem_addr <= rd_ptr;
      end else if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      // Only display-issued reads ever reach the DAC.
      rd_v1      <= in_win;
      rd_v2      <= rd_v1;
      out_valid  <= rd_v2;
      out_pixels <= rd_v2 ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter with a behavioural RAM
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int H_TOT = 440;

  typedef struct packed {logic v; logic [7:0] p;} pix_t;
  typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready, wr_err, mem_we, out_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, out_pixels;
  logic        preload;

  logic [7:0]  ram     [0:FB_DEPTH-1];
  logic [7:0]  ref_mem [0:FB_DEPTH-1];
  pix_t        sb[$];
  wr_t         wq[$];
  int          ptr;
  bit          busy;
  int          last_grant_h;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_err     (wr_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_pixels (out_pixels),
    .out_valid  (out_valid)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < FB_DEPTH; i++) ram[i] <= 8'(i);
    end else if (mem_we && mem_addr < 16'(FB_DEPTH)) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_addr < 16'(FB_DEPTH)) ? ram[mem_addr] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, act, exp, hcount, vcount, $time);
    end
  endtask

  task automatic step(input int h, input int v, input bit r);
    bit vwin, win, g, inr, n_rd;
    logic [15:0] n_addr;
    pix_t e;
    wr_t cur;
    hcount = 11'(h);
    vcount = 10'(v);
    rst    = r;
    cur.a  = 16'h0;
    cur.d  = 8'h0;
    if (wq.size() > 0) begin
      cur      = wq[0];
      wr_valid = 1'b1;
      wr_addr  = cur.a;
      wr_data  = cur.d;
    end else begin
      wr_valid = 1'b0;
    end
    vwin   = (v >= Y0) && (v <= Y0 + IMG_H - 1);
    win    = vwin && (h >= X0) && (h <= X0 + IMG_W - 1);
    inr    = int'(wr_addr) < FB_DEPTH;
    g      = !r && wr_valid && !win && !busy;
    n_rd   = !r && win;
    n_addr = 16'(ptr);
    e      = '0;
    if (r) begin
      sb = {};
      sb.push_back(pix_t'(0));
      sb.push_back(pix_t'(0));
      ptr = 0;
    end else if (!vwin) begin
      ptr = 0;
    end else if (win) begin
      e   = {1'b1, ref_mem[ptr]};
      ptr = (ptr == FB_DEPTH - 1) ? 0 : ptr + 1;
    end
    sb.push_back(e);
    busy = g;

    @(posedge clk);
    #1;
    if (r) begin
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_out_pixels_now", out_pixels, 0);
    end
    check("wr_ready", wr_ready, g);
    check("wr_err", wr_err, g && !inr);
    check("mem_we", mem_we, g && inr);
    if (g && inr) begin
      check("mem_addr_wr", mem_addr, cur.a);
      check("mem_wdata", mem_wdata, cur.d);
    end
    if (n_rd) check("mem_addr_rd", mem_addr, n_addr);
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      check("out_valid", out_valid, e.v);
      check("out_pixels", out_pixels, e.p);
    end
    if (wr_ready) last_grant_h = h;
    if (g) begin
      if (inr) ref_mem[cur.a] = cur.d;
      void'(wq.pop_front());
    end
  endtask

  task automatic line(input int v);
    for (int h = 0; h < H_TOT; h++) step(h, v, 1'b0);
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    preload = 1'b1; ptr = 0; busy = 1'b0; last_grant_h = -1;
    for (int i = 0; i < FB_DEPTH; i++) ref_mem[i] = 8'(i);
    @(posedge clk);
    #1;
    preload = 1'b0;
    step(0, 0, 1'b1);
    step(1, 0, 1'b1);

    // Frame 1: blanking write, in-window request, error address, back-to-back burst
    for (int h = 0; h < H_TOT; h++) begin
      if (h == 10) wq.push_back('{16'h0010, 8'hAB});
      step(h, Y0 - 1, 1'b0);
    end
    last_grant_h = -1;
    for (int h = 0; h < H_TOT; h++) begin
      if (h == X0 + 5) wq.push_back('{16'h0020, 8'h5C});
      step(h, Y0, 1'b0);
    end
    check("wait_grant_h", last_grant_h, X0 + IMG_W);
    for (int h = 0; h < H_TOT; h++) begin
      if (h == 20) wq.push_back('{16'(FB_DEPTH), 8'h77});
      if (h == 30)
        for (int k = 0; k < 4; k++) wq.push_back('{16'(16'h30 + k), 8'(8'h90 + k)});
      step(h, Y0 + 1, 1'b0);
    end
    line(Y0 + IMG_H);

    // Frame 2: written pixels visible, then a reset in the middle of a line
    line(Y0 - 1);
    line(Y0);
    for (int h = 0; h < H_TOT; h++) step(h, Y0 + 1, h == X0 + 100);
    line(Y0 + IMG_H);

    // Frame 3: display realigned after reset
    line(Y0);
    line(Y0 + 1);
    for (int h = 0; h < 8; h++) step(h, Y0 + IMG_H, 1'b0);

    check("write_queue_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
